arcade_input_mapper: RTL and testbench

//   Parametrised player-input front end for arcade cores: merges PS/2 keyboard events and
//   HPS joysticks into per-player direction/button/start/coin signals for the game core.

---
 rtl/arcade_input_mapper.sv | 254 +++++++++++++++++++++++++
 tb/tb_arcade_input_mapper.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/arcade_input_mapper.sv
// Player-input front end: PS/2 key latches and HPS joysticks merged into per-player
// rotated directions, buttons (button-0 autofire), start and a held-off coin pulse.

module arcade_player_lane #(
  parameter int NUM_BUTTONS   = 3,
  parameter int COIN_PULSE    = 65536,
  parameter int COIN_HOLDOFF  = 131072,
  parameter int COIN_ON_START = 1,
  parameter int ACTIVE_LOW    = 1
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic [15:0]            raw,
  input  logic [1:0]             rotate,
  input  logic                   af_phase,
  input  logic                   autofire_en,
  output logic [3:0]             dir,
  output logic [NUM_BUTTONS-1:0] btn,
  output logic                   start,
  output logic                   coin
);
  localparam int CNT_MAX = (COIN_PULSE > COIN_HOLDOFF) ? COIN_PULSE : COIN_HOLDOFF;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] PULSE_LAST = CW'(COIN_PULSE - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(COIN_HOLDOFF - 1);
  localparam logic INV         = (ACTIVE_LOW != 0);
  localparam logic START_COINS = (COIN_ON_START != 0);

  typedef enum logic [1:0] {IDLE, PULSE, HOLD} coin_st_e;

  coin_st_e               st_q, st_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [3:0]             dir_rot, dir_q;
  logic [NUM_BUTTONS-1:0] btn_raw, btn_q;
  logic                   start_q;
  logic [1:0]             coin_pipe;
  logic                   coin_trig, coin_edge;
  logic                   unused_raw;

  assign unused_raw = ^raw;

  // raw[3:0] = {up,down,left,right}; each case lists the source of {up,down,left,right}
  always_comb begin
    case (rotate)
      2'b01:   dir_rot = {raw[1], raw[0], raw[2], raw[3]};
      2'b10:   dir_rot = {raw[2], raw[3], raw[0], raw[1]};
      2'b11:   dir_rot = {raw[0], raw[1], raw[3], raw[2]};
      default: dir_rot = raw[3:0];
    endcase
  end

  always_comb begin
    btn_raw    = raw[4 +: NUM_BUTTONS];
    btn_raw[0] = raw[4] & (af_phase | ~autofire_en);
  end

  assign coin_trig = raw[5+NUM_BUTTONS] | (START_COINS & raw[4+NUM_BUTTONS]);
  assign coin_edge = coin_pipe[0] & ~coin_pipe[1];

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dir_q     <= '0;
      btn_q     <= '0;
      start_q   <= 1'b0;
      coin_pipe <= '0;
      st_q      <= IDLE;
      cnt_q     <= '0;
    end else begin
      dir_q     <= dir_rot;
      btn_q     <= btn_raw;
      start_q   <= raw[4+NUM_BUTTONS];
      coin_pipe <= {coin_pipe[0], coin_trig};
      st_q      <= st_d;
      cnt_q     <= cnt_d;
    end
  end

  // Edges seen outside IDLE are dropped, so a mashed coin key cannot queue credits
  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    case (st_q)
      IDLE: if (coin_edge) begin
        st_d  = PULSE;
        cnt_d = '0;
      end
      PULSE: if (cnt_q == PULSE_LAST) begin
        st_d  = HOLD;
        cnt_d = '0;
      end else cnt_d = cnt_q + 1'b1;
      HOLD: if (cnt_q == HOLD_LAST) begin
        st_d  = IDLE;
        cnt_d = '0;
      end else cnt_d = cnt_q + 1'b1;
      default: begin
        st_d  = IDLE;
        cnt_d = '0;
      end
    endcase
  end

  assign dir   = dir_q ^ {4{INV}};
  assign btn   = btn_q ^ {NUM_BUTTONS{INV}};
  assign start = start_q ^ INV;
  assign coin  = (st_q == PULSE) ^ INV;
endmodule

module arcade_input_mapper #(
  parameter int NUM_PLAYERS   = 2,
  parameter int NUM_BUTTONS   = 3,
  parameter int COIN_PULSE    = 65536,
  parameter int COIN_HOLDOFF  = 131072,
  parameter int COIN_ON_START = 1,
  parameter int AUTOFIRE_DIV  = 262144,
  parameter int ACTIVE_LOW    = 1
) (
  input  logic                               clk_sys,
  input  logic                               reset,
  input  logic [64:0]                        ps2_key,
  input  logic [16*NUM_PLAYERS-1:0]          joy_in,
  input  logic [1:0]                         rotate,
  input  logic                               merge_joy,
  input  logic                               autofire_en,
  output logic [4*NUM_PLAYERS-1:0]           dir_out,
  output logic [NUM_BUTTONS*NUM_PLAYERS-1:0] btn_out,
  output logic [NUM_PLAYERS-1:0]             start_out,
  output logic [NUM_PLAYERS-1:0]             coin_out
);
  localparam int NKEYS = 19;
  localparam int AW    = (AUTOFIRE_DIV > 1) ? $clog2(AUTOFIRE_DIV) : 1;
  localparam logic [AW-1:0] AF_LAST = AW'(AUTOFIRE_DIV - 1);

  logic             toggle_q, key_evt, key_pressed, key_ext;
  logic [8:0]       key_code;
  logic [NKEYS-1:0] key_hit, key_lat;
  logic [1:0][15:0] key_word;
  logic [15:0]      joy_or;
  logic [AW-1:0]    af_cnt;
  logic             af_phase;

  logic [NUM_PLAYERS-1:0][3:0]             dir_w;
  logic [NUM_PLAYERS-1:0][NUM_BUTTONS-1:0] btn_w;

  assign key_evt     = ps2_key[64] ^ toggle_q;
  assign key_pressed = ps2_key[15:8] != 8'hF0;
  assign key_ext     = key_pressed ? (ps2_key[15:8] == 8'hE0) : (ps2_key[23:16] == 8'hE0);
  assign key_code    = (|ps2_key[63:24]) ? 9'h000 : {key_ext, ps2_key[7:0]};

  // Latch order per player: right, left, down, up, buttons, start, coin
  always_comb begin
    key_hit     = '0;
    key_hit[0]  = key_code[7:0] == 8'h74;
    key_hit[1]  = key_code[7:0] == 8'h6B;
    key_hit[2]  = key_code[7:0] == 8'h72;
    key_hit[3]  = key_code[7:0] == 8'h75;
    key_hit[4]  = key_code == 9'h029;
    key_hit[5]  = key_code == 9'h014;
    key_hit[6]  = key_code == 9'h011;
    key_hit[7]  = key_code == 9'h012;
    key_hit[8]  = key_code == 9'h005;
    key_hit[9]  = key_code == 9'h02E;
    key_hit[10] = key_code == 9'h034;
    key_hit[11] = key_code == 9'h023;
    key_hit[12] = key_code == 9'h02B;
    key_hit[13] = key_code == 9'h02D;
    key_hit[14] = key_code == 9'h01C;
    key_hit[15] = key_code == 9'h01B;
    key_hit[16] = key_code == 9'h015;
    key_hit[17] = key_code == 9'h006;
    key_hit[18] = key_code == 9'h036;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      toggle_q <= 1'b0;
      key_lat  <= '0;
    end else begin
      toggle_q <= ps2_key[64];
      if (key_evt)
        for (int i = 0; i < NKEYS; i++)
          if (key_hit[i]) key_lat[i] <= key_pressed;
    end
  end

  always_comb begin
    key_word       = '0;
    key_word[0][3:0] = key_lat[3:0];
    key_word[0][4] = key_lat[4] | key_lat[5];
    if (NUM_BUTTONS > 1) key_word[0][5] = key_lat[6];
    if (NUM_BUTTONS > 2) key_word[0][6] = key_lat[7];
    key_word[0][4+NUM_BUTTONS] = key_lat[8];
    key_word[0][5+NUM_BUTTONS] = key_lat[9];
    key_word[1][3:0] = key_lat[13:10];
    key_word[1][4] = key_lat[14];
    if (NUM_BUTTONS > 1) key_word[1][5] = key_lat[15];
    if (NUM_BUTTONS > 2) key_word[1][6] = key_lat[16];
    key_word[1][4+NUM_BUTTONS] = key_lat[17];
    key_word[1][5+NUM_BUTTONS] = key_lat[18];
  end

  always_comb begin
    joy_or = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) joy_or |= joy_in[16*p +: 16];
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      af_cnt   <= '0;
      af_phase <= 1'b1;
    end else if (af_cnt == AF_LAST) begin
      af_cnt   <= '0;
      af_phase <= ~af_phase;
    end else begin
      af_cnt   <= af_cnt + 1'b1;
    end
  end

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_lane
    logic [15:0] joy_w, key_w;
    if (p == 0) begin : g_joy0
      assign joy_w = merge_joy ? joy_or : joy_in[15:0];
    end else begin : g_joyn
      assign joy_w = merge_joy ? 16'h0000 : joy_in[16*p +: 16];
    end
    // Keyboard only reaches the first two players
    if (p < 2) begin : g_key
      assign key_w = key_word[p];
    end else begin : g_nokey
      assign key_w = '0;
    end

    arcade_player_lane #(
      .NUM_BUTTONS  (NUM_BUTTONS),
      .COIN_PULSE   (COIN_PULSE),
      .COIN_HOLDOFF (COIN_HOLDOFF),
      .COIN_ON_START(COIN_ON_START),
      .ACTIVE_LOW   (ACTIVE_LOW)
    ) u_lane (
      .clk_sys    (clk_sys),
      .reset      (reset),
      .raw        (key_w | joy_w),
      .rotate     (rotate),
      .af_phase   (af_phase),
      .autofire_en(autofire_en),
      .dir        (dir_w[p]),
      .btn        (btn_w[p]),
      .start      (start_out[p]),
      .coin       (coin_out[p])
    );
  end

  assign dir_out = dir_w;
  assign btn_out = btn_w;
endmodule

// File: tb/tb_arcade_input_mapper.sv
// Directed bench for arcade_input_mapper: 2 players, 3 buttons, short coin/autofire timing.

module tb_arcade_input_mapper;
  logic        clk_sys = 1'b0;
  logic        reset = 1'b0;
  logic [64:0] ps2_key = '0;
  logic [31:0] joy_in = '0;
  logic [1:0]  rotate = 2'b00;
  logic        merge_joy = 1'b0;
  logic        autofire_en = 1'b0;
  logic [7:0]  dir_out;
  logic [5:0]  btn_out;
  logic [1:0]  start_out;
  logic [1:0]  coin_out;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_sys = ~clk_sys;

  arcade_input_mapper #(
    .NUM_PLAYERS(2), .NUM_BUTTONS(3), .COIN_PULSE(4), .COIN_HOLDOFF(8),
    .COIN_ON_START(1), .AUTOFIRE_DIV(4), .ACTIVE_LOW(1)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .ps2_key(ps2_key), .joy_in(joy_in),
    .rotate(rotate), .merge_joy(merge_joy), .autofire_en(autofire_en),
    .dir_out(dir_out), .btn_out(btn_out), .start_out(start_out), .coin_out(coin_out)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic key(input logic [63:0] b);
    ps2_key = {~ps2_key[64], b};
  endtask

  initial begin
    logic       act;
    logic [5:0] exp_b;

    // 1: reset and idle
    #2 reset = 1'b1;
    step(2);
    chk("rst_dir", dir_out, 8'hFF);
    chk("rst_btn", btn_out, 6'h3F);
    chk("rst_start", start_out, 2'b11);
    chk("rst_coin", coin_out, 2'b11);
    reset = 1'b0;
    step(100);
    chk("idle_dir", dir_out, 8'hFF);
    chk("idle_btn", btn_out, 6'h3F);
    chk("idle_start", start_out, 2'b11);
    chk("idle_coin", coin_out, 2'b11);

    // 2: keyboard, two-cycle latency
    key(64'h0000_0000_0000_E075);
    step(1);
    chk("key_up_lat1", dir_out, 8'hFF);
    step(1);
    chk("key_up_press", dir_out, 8'hF7);
    key(64'h0000_0000_00E0_F075);
    step(2);
    chk("key_up_release", dir_out, 8'hFF);
    key(64'h0000_0000_0000_0075);
    step(2);
    chk("key_up_noext", dir_out, 8'hF7);
    rotate = 2'b01;
    step(1);
    chk("key_rot_hold", dir_out, 8'hFE);
    rotate = 2'b00;
    step(1);
    chk("key_rot_back", dir_out, 8'hF7);
    key(64'h0000_0000_0000_F075);
    step(2);
    chk("key_noext_rel", dir_out, 8'hFF);
    key(64'h0100_0000_0000_E075);
    step(2);
    chk("key_highbytes", dir_out, 8'hFF);
    key(64'h0000_0000_0000_001B);
    step(2);
    chk("key_p2_btn1", btn_out, 6'h2F);
    key(64'h0000_0000_0000_F01B);
    step(2);
    chk("key_p2_btn1_rel", btn_out, 6'h3F);

    // 3: joystick rotation and merge
    joy_in = 32'h0000_0008;
    rotate = 2'b01;
    step(1);
    chk("rot90", dir_out, 8'hFE);
    rotate = 2'b10;
    step(1);
    chk("rot180", dir_out, 8'hFB);
    rotate = 2'b11;
    step(1);
    chk("rot270", dir_out, 8'hFD);
    rotate = 2'b00;
    joy_in = '0;
    step(1);
    chk("rot_clear", dir_out, 8'hFF);
    joy_in = 32'h0001_0000;
    step(1);
    chk("p2_right", dir_out, 8'hEF);
    merge_joy = 1'b1;
    step(1);
    chk("merge_p1", dir_out, 8'hFE);
    merge_joy = 1'b0;
    joy_in = '0;
    step(1);
    chk("merge_clear", dir_out, 8'hFF);

    // 4: start key coins, pulse length and holdoff
    key(64'h0000_0000_0000_0005);
    step(2);
    chk("start_p1", start_out, 2'b10);
    chk("coin_lat2", coin_out, 2'b11);
    step(1);
    for (int i = 0; i < 4; i++) begin
      chk("coin_pulse", coin_out, 2'b10);
      step(1);
    end
    chk("coin_end", coin_out, 2'b11);
    key(64'h0000_0000_0000_F005);
    step(2);
    key(64'h0000_0000_0000_0005);
    for (int i = 0; i < 6; i++) begin
      step(1);
      chk("coin_holdoff", coin_out, 2'b11);
    end
    key(64'h0000_0000_0000_F005);
    step(3);
    key(64'h0000_0000_0000_0005);
    step(2);
    chk("coin_again_lat", coin_out, 2'b11);
    step(1);
    chk("coin_again", coin_out, 2'b10);
    key(64'h0000_0000_0000_F005);
    step(14);
    chk("start_rel", start_out, 2'b11);
    chk("coin_idle", coin_out, 2'b11);
    joy_in = 32'h0100_0000;
    step(1);
    chk("p2_coin_lat1", coin_out, 2'b11);
    step(1);
    chk("p2_coin", coin_out, 2'b01);
    joy_in = '0;
    step(14);

    // 6: reset mid pulse
    joy_in = 32'h0000_0100;
    step(2);
    chk("coin_joy_p1", coin_out, 2'b10);
    step(1);
    ps2_key = {ps2_key[64], 64'h0};
    reset = 1'b1;
    #1;
    chk("rst_mid_coin", coin_out, 2'b11);
    joy_in = '0;
    autofire_en = 1'b1;
    step(2);
    reset = 1'b0;
    joy_in = 32'h0000_0010;

    // 5: autofire from a known counter origin
    for (int i = 1; i <= 12; i++) begin
      step(1);
      act = (((i - 1) / 4) % 2) == 0;
      exp_b = {5'h1F, ~act};
      chk("autofire", btn_out, exp_b);
      chk("rst_coin_idle", coin_out, 2'b11);
    end
    autofire_en = 1'b0;
    step(1);
    chk("autofire_off", btn_out, 6'h3E);
    joy_in = '0;
    step(1);
    chk("btn_clear", btn_out, 6'h3F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
